bcd_10_2: RTL
=============

Name: bcd_10_2

Overview:
- Iterative BCD-to-binary converter. It is the inverse companion of the team's binary-to-BCD digit pipeline.
- Accepts one packed NUM_DIGITS-digit BCD word through a valid/ready handshake.
- Computes the binary value MSD-first as acc = acc*10 + digit, one digit per enabled cycle.
- Presents the result through a valid/ready output handshake, with overflow and (optional) invalid-digit flags.
- Sits downstream of BCD display/keypad data paths that feed binary arithmetic.

Parameters:
- NUM_DIGITS, 3, number of 4-bit BCD digits in digitIn (>=1).
- BIN_WIDTH, 10, width of binOut; the result is value mod 2^BIN_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset; 0 resets immediately, released synchronously by the integrator.
- ena  input  1  clock enable; when 0, all registers and the FSM hold.
- in_valid  input  1  digitIn holds a word to convert.
- in_ready  output  1  block can accept a word.
- digitIn  input  [NUM_DIGITS-1:0][3:0]  BCD digits; index 0 = least significant.
- out_valid  output  1  binOut/ovf/err hold a completed result.
- out_ready  input  1  downstream consumes the result.
- binOut  output  BIN_WIDTH  binary result.
- ovf  output  1  true decimal value >= 2^BIN_WIDTH.
- err  output  1  invalid digit (>9) present (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - out_valid=0, binOut=0, ovf=0, err=0.
  - Digit register, accumulator and counter cleared.
- FSM states: IDLE, CONV, DONE. All transitions require ena=1; with ena=0 every register holds.
- in_ready = (state==IDLE) & ena, combinational.
- IDLE:
  - On in_valid & in_ready, latch digitIn, clear acc and the sticky ovf, set cnt=NUM_DIGITS-1, go to CONV.
  - Otherwise stay.
- CONV:
  - Each enabled cycle: acc <= acc*10 + digit[cnt], with *10 implemented as (acc<<3)+(acc<<1).
  - acc width is BIN_WIDTH+4.
  - The sticky ovf bit is set if any bit at or above BIN_WIDTH is nonzero after the step.
  - acc is then truncated to BIN_WIDTH bits for the next step.
  - cnt decrements; after the step with cnt==0, go to DONE and register binOut, ovf, err.
- Latency:
  - Acceptance edge E.
  - out_valid rises after edge E+NUM_DIGITS, counting enabled edges only.
- DONE:
  - out_valid=1; binOut, ovf and err stay stable until the handshake.
  - On out_valid & out_ready & ena, drop out_valid and go to IDLE.
  - No new word is accepted in the same cycle; throughput is one word per NUM_DIGITS+2 enabled cycles.
- out_valid and the flags stay asserted indefinitely under backpressure.
- Reset mid-CONV or mid-DONE: the result is discarded and the block returns to IDLE with outputs cleared.
- Inputs are ignored outside IDLE; digitIn may change freely after acceptance.
- NUM_DIGITS=1: a single CONV cycle.

Optional Feature:
- Macro BCD_10_2_DIGIT_CHECK_EN.
- Defined:
  - At acceptance, err_flag = OR over digits of (digit>9).
  - In DONE, err=err_flag.
  - If err=1, binOut is forced to 0 and ovf to 0.
- Undefined:
  - err is constant 0.
  - Digits >9 are used arithmetically, so binOut = (sum digit[k]*10^k) mod 2^BIN_WIDTH.
  - ovf is computed normally.

Test Plan (NUM_DIGITS=3, BIN_WIDTH=10 unless noted):
- digitIn 1,2,3 (123), out_ready=1 -> out_valid after 3 enabled edges, binOut=0x07B, ovf=0, err=0; in_ready back to 1 the next cycle.
- 999 then 000 back-to-back, in_valid held -> binOut=0x3E7 then binOut=0x000; second word accepted only after the first handshake.
- BIN_WIDTH=8, input 256 -> binOut=0x00, ovf=1; input 255 -> binOut=0xFF, ovf=0.
- Input 500, out_ready=0 for 10 cycles, with ena toggled low 2 cycles during CONV -> out_valid delayed by exactly 2 cycles; binOut=0x1F4 held stable throughout, consumed when out_ready=1.
- rst pulsed low during CONV -> out_valid=0, binOut=0, in_ready=1 after release; a new input 42 gives binOut=0x02A.
- Digits 1,A,0:
  - With macro defined: err=1, binOut=0.
  - Without macro: err=0, binOut=100+100=200=0x0C8.

Source files
------------

// File: rtl/bcd_10_2.sv
// Iterative BCD-to-binary converter: one digit per enabled cycle, MSD first, acc = acc*10 + digit.
// Optional invalid-digit detection is enabled by defining BCD_10_2_DIGIT_CHECK_EN.
module bcd_10_2 #(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_WIDTH  = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_DIGITS-1:0][3:0]  digitIn,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BIN_WIDTH-1:0]        binOut,
  output logic                        ovf,
  output logic                        err
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int ACC_W = BIN_WIDTH + 4;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                       state;
  logic [NUM_DIGITS-1:0][3:0]   digitReg;
  logic [BIN_WIDTH-1:0]         acc;
  logic [CNT_W-1:0]             cnt;
  logic                         ovfSticky;
  logic                         errFlag;

  logic [ACC_W-1:0]             accWide;
  logic [ACC_W-1:0]             stepSum;
  logic                         stepOvf;
  logic [3:0]                   curDigit;
  logic                         inErr;

  assign in_ready = (state == IDLE) & ena;

  // The four spare accumulator bits can hold (2^BIN_WIDTH-1)*10+15, so any overflow shows up there.
  always_comb begin
    accWide  = {4'b0000, acc};
    curDigit = digitReg[cnt];
    stepSum  = (accWide << 3) + (accWide << 1) + ACC_W'(curDigit);
    stepOvf  = |stepSum[ACC_W-1:BIN_WIDTH];
  end

  always_comb begin
    inErr = 1'b0;
`ifdef BCD_10_2_DIGIT_CHECK_EN
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digitIn[k] > 4'd9) inErr = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      digitReg  <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovfSticky <= 1'b0;
      errFlag   <= 1'b0;
      out_valid <= 1'b0;
      binOut    <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            digitReg  <= digitIn;
            acc       <= '0;
            ovfSticky <= 1'b0;
            errFlag   <= inErr;
            cnt       <= CNT_W'(NUM_DIGITS - 1);
            state     <= CONV;
          end
        end
        CONV: begin
          acc       <= stepSum[BIN_WIDTH-1:0];
          ovfSticky <= ovfSticky | stepOvf;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef BCD_10_2_DIGIT_CHECK_EN
            if (errFlag) begin
              binOut <= '0;
              ovf    <= 1'b0;
              err    <= 1'b1;
            end else begin
              binOut <= stepSum[BIN_WIDTH-1:0];
              ovf    <= ovfSticky | stepOvf;
              err    <= 1'b0;
            end
`else
            binOut <= stepSum[BIN_WIDTH-1:0];
            ovf    <= ovfSticky | stepOvf;
            err    <= errFlag;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
